// File: rtl/ifetch_assembler_pkg.sv
// Shared types and widths for the instruction-fetch assembler.
// The fetch controller and the IR packer both use these.
package ifetch_assembler_pkg;

  typedef enum logic {StFetch, StHold} fetch_state_e;

  localparam int unsigned IsaInstrW    = 32;
  localparam int unsigned DefaultMemW  = 8;
  localparam int unsigned DefaultAddrW = 8;

  // Width of a beat index. It is at least 1 so that BEATS==1 still has a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ifetch_assembler_ir_packer.sv
// Instruction register made of BEATS lanes of MEM_W bits.
// Each accepted beat writes the one lane its index selects.
module ifetch_assembler_ir_packer
  import ifetch_assembler_pkg::*;
#(
  parameter int unsigned MEM_W = DefaultMemW,
  parameter int unsigned BEATS = 4,
  parameter int unsigned IDX_W = idx_width(BEATS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic [MEM_W-1:0]       wdata_i,
  output logic [BEATS*MEM_W-1:0] instr_o
);

  logic [BEATS*MEM_W-1:0] ir_q, ir_d;

  always_comb begin
    ir_d = ir_q;
    for (int i = 0; i < BEATS; i++) begin
      if (we_i && (idx_i == IDX_W'(i))) begin
        ir_d[i*MEM_W +: MEM_W] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir_q <= '0;
    end else begin
      ir_q <= ir_d;
    end
  end

  assign instr_o = ir_q;

endmodule

// File: rtl/ifetch_assembler.sv
// Instruction-fetch unit. It owns the PC and issues BEATS narrow reads per instruction.
// It then presents the assembled instruction to decode over a valid/ready handshake.
module ifetch_assembler
  import ifetch_assembler_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefaultAddrW,
  parameter int unsigned       MEM_W    = DefaultMemW,
  parameter int unsigned       INSTR_W  = IsaInstrW,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_adr,
  input  logic               mem_ack,
  input  logic [MEM_W-1:0]   mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pcvalue,
  output logic [ADDR_W-1:0]  nextpcvalue,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int unsigned       BEATS     = INSTR_W / MEM_W;
  localparam int unsigned       IdxW      = idx_width(BEATS);
  localparam logic [IdxW-1:0]   LastBeat  = IdxW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] BeatsAddr = ADDR_W'(BEATS);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [IdxW-1:0]   beat_q, beat_d;
  logic              started_q, started_d;
  logic              ir_we;

  assign pcvalue     = pc_q;
  assign nextpcvalue = pc_q + BeatsAddr;
  assign mem_adr     = pc_q + ADDR_W'(beat_q);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    beat_d      = beat_q;
    started_d   = 1'b1;
    ir_we       = 1'b0;
    // The request stays quiet for one cycle after reset is released.
    mem_req     = (state_q == StFetch) && started_q;
    instr_valid = (state_q == StHold);

    if (redirect) begin
      pc_d    = redirect_pc;
      beat_d  = '0;
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (mem_req && mem_ack) begin
            ir_we = 1'b1;
            if (beat_q == LastBeat) begin
              beat_d  = '0;
              state_d = StHold;
            end else begin
              beat_d = beat_q + IdxW'(1);
            end
          end
        end
        StHold: begin
          if (instr_ready) begin
            pc_d    = nextpcvalue;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      beat_q    <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      beat_q    <= beat_d;
      started_q <= started_d;
    end
  end

  ifetch_assembler_ir_packer #(
    .MEM_W (MEM_W),
    .BEATS (BEATS),
    .IDX_W (IdxW)
  ) u_ir_packer (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (ir_we),
    .idx_i   (beat_q),
    .wdata_i (mem_rdata),
    .instr_o (instr)
  );

endmodule

// File: tb/tb_ifetch_assembler.sv
// Directed bench for ifetch_assembler. An 8-bit-beat instance and a 16-bit-beat instance share
// one scoreboard that holds the expected {pc, instr} of each completed fetch.
module tb_ifetch_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit beat instance
  logic        reset8, ack8, ready8, redir8;
  logic [7:0]  redir_pc8, adr8, rdata8, pc8, npc8;
  logic        req8, valid8;
  logic [31:0] instr8;
  logic [7:0]  mem8 [256];

  // 16-bit beat instance
  logic        reset16, ack16, ready16, redir16;
  logic [7:0]  redir_pc16, adr16, pc16, npc16;
  logic [15:0] rdata16;
  logic        req16, valid16;
  logic [31:0] instr16;
  logic [15:0] mem16 [256];

  assign rdata8  = mem8[adr8];
  assign rdata16 = mem16[adr16];

  ifetch_assembler #(
    .ADDR_W (8), .MEM_W (8), .INSTR_W (32), .RESET_PC (8'h00)
  ) dut8 (
    .clk (clk), .reset (reset8), .mem_req (req8), .mem_adr (adr8), .mem_ack (ack8),
    .mem_rdata (rdata8), .instr (instr8), .instr_valid (valid8), .instr_ready (ready8),
    .pcvalue (pc8), .nextpcvalue (npc8), .redirect (redir8), .redirect_pc (redir_pc8)
  );

  ifetch_assembler #(
    .ADDR_W (8), .MEM_W (16), .INSTR_W (32), .RESET_PC (8'h00)
  ) dut16 (
    .clk (clk), .reset (reset16), .mem_req (req16), .mem_adr (adr16), .mem_ack (ack16),
    .mem_rdata (rdata16), .instr (instr16), .instr_valid (valid16), .instr_ready (ready16),
    .pcvalue (pc16), .nextpcvalue (npc16), .redirect (redir16), .redirect_pc (redir_pc16)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [39:0] sb_q [$];   // {pc, instr}

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] pc, input logic [31:0] ins);
    logic [39:0] exp;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 40'd0, 40'd1);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, {pc, ins}, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem8[i]  = 8'(i * 7 + 3);
      mem16[i] = 16'(i * 257 + 1);
    end
    mem8[0] = 8'h20; mem8[1] = 8'h20; mem8[2] = 8'h85; mem8[3] = 8'h00;
    mem8[4] = 8'h11; mem8[5] = 8'h22; mem8[6] = 8'h33; mem8[7] = 8'h44;
    mem8[8'h40] = 8'hde; mem8[8'h41] = 8'had; mem8[8'h42] = 8'hbe; mem8[8'h43] = 8'hef;
    mem8[8'hfc] = 8'h01; mem8[8'hfd] = 8'h02; mem8[8'hfe] = 8'h03; mem8[8'hff] = 8'h04;
    mem16[0] = 16'h1234; mem16[1] = 16'habcd;

    reset8 = 1'b1; ack8 = 1'b0; ready8 = 1'b0; redir8 = 1'b0; redir_pc8 = 8'h00;
    reset16 = 1'b1; ack16 = 1'b0; ready16 = 1'b0; redir16 = 1'b0; redir_pc16 = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 40'(valid8), 40'd0);
    chk("rst_req", 40'(req8), 40'd0);
    chk("rst_pc", 40'(pc8), 40'h00);
    chk("rst_instr", 40'(instr8), 40'h0);
    chk("rst_npc", 40'(npc8), 40'h04);

    // 1: zero-wait fetch from pc 0
    reset8 = 1'b0; ack8 = 1'b1;
    sb_q.push_back({8'h00, 32'h00852020});
    #1 chk("s1_req_quiet", 40'(req8), 40'd0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("s1_adr", {7'd0, req8, 24'd0, adr8}, {7'd0, 1'b1, 24'd0, 8'(b)});
      chk("s1_no_valid", 40'(valid8), 40'd0);
    end
    @(negedge clk);
    chk("s1_valid", 40'(valid8), 40'd1);
    pop_chk("s1_instr", pc8, instr8);
    chk("s1_npc", 40'(npc8), 40'h04);

    // 2: consumer stalls for 5 cycles
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s2_hold", {6'd0, req8, valid8, pc8, instr8}, {6'd0, 1'b0, 1'b1, 8'h00, 32'h00852020});
    end
    ready8 = 1'b1;
    @(negedge clk);
    ready8 = 1'b0; ack8 = 1'b0;
    chk("s2_after", {6'd0, req8, valid8, pc8, adr8, 16'd0}, {6'd0, 1'b1, 1'b0, 8'h04, 8'h04, 16'd0});

    // 3: ack delayed by 3 cycles per beat
    sb_q.push_back({8'h04, 32'h44332211});
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        chk("s3_adr", {7'd0, valid8, 24'd0, adr8}, {7'd0, 1'b0, 24'd0, 8'(4 + b)});
        ack8 = (k == 3);
        @(negedge clk);
      end
    end
    ack8 = 1'b0;
    chk("s3_valid", 40'(valid8), 40'd1);
    pop_chk("s3_instr", pc8, instr8);

    // 4: redirect during beat 2 with a simultaneous ack
    ready8 = 1'b1;
    @(negedge clk);
    ready8 = 1'b0; ack8 = 1'b1;
    chk("s4_adr0", 40'(adr8), 40'h08);
    @(negedge clk);
    chk("s4_adr1", 40'(adr8), 40'h09);
    @(negedge clk);
    chk("s4_adr2", 40'(adr8), 40'h0a);
    redir8 = 1'b1; redir_pc8 = 8'h40;
    sb_q.push_back({8'h40, 32'hefbeadde});
    @(negedge clk);
    redir8 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("s4_redir", {6'd0, req8, valid8, 24'd0, adr8}, {6'd0, 1'b1, 1'b0, 24'd0, 8'(8'h40 + b)});
      @(negedge clk);
    end
    chk("s4_valid", 40'(valid8), 40'd1);
    pop_chk("s4_instr", pc8, instr8);

    // 5: redirect from HOLD to a PC near the top of memory, then wrap
    redir8 = 1'b1; redir_pc8 = 8'hfc;
    sb_q.push_back({8'hfc, 32'h04030201});
    @(negedge clk);
    redir8 = 1'b0;
    chk("s5_valid_drop", 40'(valid8), 40'd0);
    for (int b = 0; b < 4; b++) begin
      chk("s5_adr", 40'(adr8), 40'(8'(8'hfc + b)));
      @(negedge clk);
    end
    chk("s5_valid", 40'(valid8), 40'd1);
    pop_chk("s5_instr", pc8, instr8);
    chk("s5_npc_wrap", 40'(npc8), 40'h00);

    // 6: 16-bit beats, then asynchronous reset in the middle of a beat
    reset16 = 1'b0; ack16 = 1'b1;
    sb_q.push_back({8'h00, 32'habcd1234});
    @(negedge clk);
    chk("s6_adr0", 40'(adr16), 40'h00);
    @(negedge clk);
    chk("s6_adr1", 40'(adr16), 40'h01);
    @(negedge clk);
    chk("s6_valid", 40'(valid16), 40'd1);
    pop_chk("s6_instr", pc16, instr16);
    chk("s6_npc", 40'(npc16), 40'h02);
    ready16 = 1'b1;
    @(negedge clk);
    ready16 = 1'b0; ack16 = 1'b0;
    chk("s6_adr_next", {7'd0, req16, 24'd0, adr16}, {7'd0, 1'b1, 24'd0, 8'h02});
    @(negedge clk);
    reset16 = 1'b1;
    #1;
    chk("s6_async_rst", {6'd0, req16, valid16, pc16, instr16}, {6'd0, 1'b0, 1'b0, 8'h00, 32'h0});

    chk("sb_drained", 40'(sb_q.size()), 40'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
